// File: rtl/mem_port_arbiter.sv
// Arbitrates one unified memory between fetch and data ports, with req/ack backend handshake and timeout.
// Latency: done 2 cycles after grant with same-cycle ack, 1 cycle on address error; 1 access per 3 cycles.
module mem_port_arbiter #(
    parameter logic [63:0] ADDR_LIMIT = 64'd8192,
    parameter int          TIMEOUT    = 16,
    parameter int          STARVE_LIM = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        if_req_i,
    input  logic [63:0] if_addr_i,
    output logic [79:0] if_rdata_o,
    output logic        if_done_o,
    output logic        if_err_o,
    output logic        if_stall_o,
    input  logic        dm_req_i,
    input  logic        dm_we_i,
    input  logic [63:0] dm_addr_i,
    input  logic [63:0] dm_wdata_i,
    output logic [63:0] dm_rdata_o,
    output logic        dm_done_o,
    output logic        dm_err_o,
    output logic        dm_stall_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [63:0] mem_addr_o,
    output logic [63:0] mem_wdata_o,
    input  logic [79:0] mem_rdata_i,
    input  logic        mem_ack_i
);

    localparam int TIMER_W  = $clog2(TIMEOUT + 1);
    localparam int STARVE_W = $clog2(STARVE_LIM + 1);
    localparam logic [TIMER_W-1:0]  TIMER_MAX  = TIMER_W'(TIMEOUT - 1);
    localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIM);

    typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_DM, RESP} state_t;

    state_t              state;
    logic [TIMER_W-1:0]  timer;
    logic [STARVE_W-1:0] starve_cnt;

    logic [64:0] if_end;
    logic [64:0] dm_end;
    logic        if_ok;
    logic        dm_ok;
    logic        grant_if;

    // 65-bit sums so an address near 2^64 cannot wrap into range
    assign if_end   = {1'b0, if_addr_i} + 65'd10;
    assign dm_end   = {1'b0, dm_addr_i} + 65'd8;
    assign if_ok    = if_end <= {1'b0, ADDR_LIMIT};
    assign dm_ok    = dm_end <= {1'b0, ADDR_LIMIT};
    assign grant_if = if_req_i && (!dm_req_i || starve_cnt == STARVE_MAX);

    assign if_stall_o = if_req_i & ~if_done_o;
    assign dm_stall_o = dm_req_i & ~dm_done_o;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= IDLE;
            timer       <= '0;
            starve_cnt  <= '0;
            if_rdata_o  <= '0;
            if_done_o   <= 1'b0;
            if_err_o    <= 1'b0;
            dm_rdata_o  <= '0;
            dm_done_o   <= 1'b0;
            dm_err_o    <= 1'b0;
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
        end else begin
            if_done_o <= 1'b0;
            if_err_o  <= 1'b0;
            dm_done_o <= 1'b0;
            dm_err_o  <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_if) begin
                        starve_cnt <= '0;
                        if (if_ok) begin
                            mem_req_o  <= 1'b1;
                            mem_we_o   <= 1'b0;
                            mem_addr_o <= if_addr_i;
                            timer      <= '0;
                            state      <= BUSY_IF;
                        end else begin
                            if_done_o <= 1'b1;
                            if_err_o  <= 1'b1;
                            state     <= RESP;
                        end
                    end else if (dm_req_i) begin
                        if (!if_req_i)
                            starve_cnt <= '0;
                        else if (starve_cnt != STARVE_MAX)
                            starve_cnt <= starve_cnt + 1'b1;
                        if (dm_ok) begin
                            mem_req_o   <= 1'b1;
                            mem_we_o    <= dm_we_i;
                            mem_addr_o  <= dm_addr_i;
                            mem_wdata_o <= dm_wdata_i;
                            timer       <= '0;
                            state       <= BUSY_DM;
                        end else begin
                            dm_done_o <= 1'b1;
                            dm_err_o  <= 1'b1;
                            state     <= RESP;
                        end
                    end
                end
                BUSY_IF, BUSY_DM: begin
                    if (mem_ack_i) begin
                        mem_req_o <= 1'b0;
                        state     <= RESP;
                        if (state == BUSY_IF) begin
                            if_rdata_o <= mem_rdata_i;
                            if_done_o  <= 1'b1;
                        end else begin
                            if (!mem_we_o)
                                dm_rdata_o <= mem_rdata_i[63:0];
                            dm_done_o <= 1'b1;
                        end
                    end else if (timer == TIMER_MAX) begin
                        mem_req_o <= 1'b0;
                        state     <= RESP;
                        if (state == BUSY_IF) begin
                            if_done_o <= 1'b1;
                            if_err_o  <= 1'b1;
                        end else begin
                            dm_done_o <= 1'b1;
                            dm_err_o  <= 1'b1;
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                RESP: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed per-cycle vector table plus hand-written starvation, timeout and async-reset sequences.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req = 1'b0;
    logic [63:0] if_addr = '0;
    logic [79:0] if_rdata;
    logic        if_done, if_err, if_stall;
    logic        dm_req = 1'b0;
    logic        dm_we = 1'b0;
    logic [63:0] dm_addr = '0;
    logic [63:0] dm_wdata = '0;
    logic [63:0] dm_rdata;
    logic        dm_done, dm_err, dm_stall;
    logic        mem_req, mem_we;
    logic [63:0] mem_addr, mem_wdata;
    logic [79:0] mem_rdata = '0;
    logic        mem_ack = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_port_arbiter dut (
        .clk_i(clk), .rst_i(rst),
        .if_req_i(if_req), .if_addr_i(if_addr), .if_rdata_o(if_rdata),
        .if_done_o(if_done), .if_err_o(if_err), .if_stall_o(if_stall),
        .dm_req_i(dm_req), .dm_we_i(dm_we), .dm_addr_i(dm_addr), .dm_wdata_i(dm_wdata),
        .dm_rdata_o(dm_rdata), .dm_done_o(dm_done), .dm_err_o(dm_err), .dm_stall_o(dm_stall),
        .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
        .mem_rdata_i(mem_rdata), .mem_ack_i(mem_ack)
    );

    typedef struct {
        logic        if_req;
        logic [63:0] if_addr;
        logic        dm_req;
        logic        dm_we;
        logic [63:0] dm_addr;
        logic [63:0] dm_wdata;
        logic        ack;
        logic [79:0] rdata;
        logic        e_mem_req;
        logic        e_mem_we;
        logic [63:0] e_mem_addr;
        logic [63:0] e_mem_wdata;
        logic        e_if_done;
        logic        e_if_err;
        logic        e_dm_done;
        logic        e_dm_err;
        logic        e_if_stall;
        logic        e_dm_stall;
        logic [79:0] e_if_rdata;
        logic [63:0] e_dm_rdata;
    } vec_t;

    vec_t vecs[$];

    localparam logic [79:0] R1 = 80'h0000_0000_0000_0100_30F2;
    localparam logic [79:0] R2 = 80'h1111_2222_3333_4444_5555;
    localparam logic [79:0] R3 = 80'hAAAA_0123_4567_89AB_CDEF;
    localparam logic [63:0] R3L = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] WD = 64'hDEAD;

    function automatic vec_t mk(
        input logic ifr, input logic [63:0] ifa, input logic dmr, input logic dmwe,
        input logic [63:0] dma, input logic [63:0] dmwd, input logic ack, input logic [79:0] rd,
        input logic emr, input logic emwe, input logic [63:0] ema, input logic [63:0] emwd,
        input logic eid, input logic eie, input logic edd, input logic ede,
        input logic eis, input logic eds, input logic [79:0] eird, input logic [63:0] edrd);
        vec_t v;
        v.if_req = ifr; v.if_addr = ifa; v.dm_req = dmr; v.dm_we = dmwe;
        v.dm_addr = dma; v.dm_wdata = dmwd; v.ack = ack; v.rdata = rd;
        v.e_mem_req = emr; v.e_mem_we = emwe; v.e_mem_addr = ema; v.e_mem_wdata = emwd;
        v.e_if_done = eid; v.e_if_err = eie; v.e_dm_done = edd; v.e_dm_err = ede;
        v.e_if_stall = eis; v.e_dm_stall = eds; v.e_if_rdata = eird; v.e_dm_rdata = edrd;
        return v;
    endfunction

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int dm_grants;
        int busy;
        int quiet_bad;
        logic got_if;
        logic done_seen;

        // single fetch with same-cycle ack
        vecs.push_back(mk(1, 64'h0, 0, 0, 0, 0, 1, R1,   0, 0, 0, 0,        0, 0, 0, 0, 1, 0, 0, 0));
        vecs.push_back(mk(1, 64'h0, 0, 0, 0, 0, 1, R1,   1, 0, 64'h0, 0,    0, 0, 0, 0, 1, 0, 0, 0));
        vecs.push_back(mk(1, 64'h0, 0, 0, 0, 0, 1, R1,   0, 0, 0, 0,        1, 0, 0, 0, 0, 0, R1, 0));
        vecs.push_back(mk(0, 64'h0, 0, 0, 0, 0, 1, R1,   0, 0, 0, 0,        0, 0, 0, 0, 0, 0, R1, 0));
        // simultaneous requests: data write first, fetch 3 cycles later
        vecs.push_back(mk(1, 64'h40, 1, 1, 64'h100, WD, 1, R2, 0, 0, 0, 0,          0, 0, 0, 0, 1, 1, R1, 0));
        vecs.push_back(mk(1, 64'h40, 1, 1, 64'h100, WD, 1, R2, 1, 1, 64'h100, WD,   0, 0, 0, 0, 1, 1, R1, 0));
        vecs.push_back(mk(1, 64'h40, 1, 1, 64'h100, WD, 1, R2, 0, 0, 0, 0,          0, 0, 1, 0, 1, 0, R1, 0));
        vecs.push_back(mk(1, 64'h40, 0, 0, 0, 0, 1, R2,        0, 0, 0, 0,          0, 0, 0, 0, 1, 0, R1, 0));
        vecs.push_back(mk(1, 64'h40, 0, 0, 0, 0, 1, R2,        1, 0, 64'h40, 0,     0, 0, 0, 0, 1, 0, R1, 0));
        vecs.push_back(mk(1, 64'h40, 0, 0, 0, 0, 1, R2,        0, 0, 0, 0,          1, 0, 0, 0, 0, 0, R2, 0));
        vecs.push_back(mk(0, 64'h40, 0, 0, 0, 0, 1, R2,        0, 0, 0, 0,          0, 0, 0, 0, 0, 0, R2, 0));
        // data read at 8188 is out of range: error one cycle after grant, no backend request
        vecs.push_back(mk(0, 0, 1, 0, 64'd8188, 0, 1, R2,      0, 0, 0, 0,          0, 0, 0, 0, 0, 1, R2, 0));
        vecs.push_back(mk(0, 0, 1, 0, 64'd8188, 0, 1, R2,      0, 0, 0, 0,          0, 0, 1, 1, 0, 0, R2, 0));
        // fetch at 8183 overruns the limit by one byte
        vecs.push_back(mk(1, 64'd8183, 0, 0, 0, 0, 1, R3,      0, 0, 0, 0,          0, 0, 0, 0, 1, 0, R2, 0));
        vecs.push_back(mk(1, 64'd8183, 0, 0, 0, 0, 1, R3,      0, 0, 0, 0,          1, 1, 0, 0, 0, 0, R2, 0));
        vecs.push_back(mk(0, 64'd8183, 0, 0, 0, 0, 1, R3,      0, 0, 0, 0,          0, 0, 0, 0, 0, 0, R2, 0));
        // data read at 8184 ends exactly at the limit and is legal
        vecs.push_back(mk(0, 0, 1, 0, 64'd8184, 0, 1, R3,      0, 0, 0, 0,          0, 0, 0, 0, 0, 1, R2, 0));
        vecs.push_back(mk(0, 0, 1, 0, 64'd8184, 0, 1, R3,      1, 0, 64'd8184, 0,   0, 0, 0, 0, 0, 1, R2, 0));
        vecs.push_back(mk(0, 0, 1, 0, 64'd8184, 0, 1, R3,      0, 0, 0, 0,          0, 0, 1, 0, 0, 0, R2, R3L));
        vecs.push_back(mk(0, 0, 0, 0, 64'd8184, 0, 1, R3,      0, 0, 0, 0,          0, 0, 0, 0, 0, 0, R2, R3L));

        // reset state
        step();
        step();
        chk("rst_mem_req", 80'(mem_req), 80'd0);
        chk("rst_mem_we", 80'(mem_we), 80'd0);
        chk("rst_mem_addr", 80'(mem_addr), 80'd0);
        chk("rst_if_done", 80'(if_done), 80'd0);
        chk("rst_dm_done", 80'(dm_done), 80'd0);
        chk("rst_if_rdata", if_rdata, 80'd0);
        chk("rst_dm_rdata", 80'(dm_rdata), 80'd0);
        rst = 1'b0;

        foreach (vecs[i]) begin
            if_req = vecs[i].if_req;   if_addr = vecs[i].if_addr;
            dm_req = vecs[i].dm_req;   dm_we = vecs[i].dm_we;
            dm_addr = vecs[i].dm_addr; dm_wdata = vecs[i].dm_wdata;
            mem_ack = vecs[i].ack;     mem_rdata = vecs[i].rdata;
            #1;
            chk($sformatf("v%0d_mem_req", i), 80'(mem_req), 80'(vecs[i].e_mem_req));
            if (vecs[i].e_mem_req) begin
                chk($sformatf("v%0d_mem_we", i), 80'(mem_we), 80'(vecs[i].e_mem_we));
                chk($sformatf("v%0d_mem_addr", i), 80'(mem_addr), 80'(vecs[i].e_mem_addr));
                if (vecs[i].e_mem_we)
                    chk($sformatf("v%0d_mem_wdata", i), 80'(mem_wdata), 80'(vecs[i].e_mem_wdata));
            end
            chk($sformatf("v%0d_if_done", i), 80'(if_done), 80'(vecs[i].e_if_done));
            chk($sformatf("v%0d_if_err", i), 80'(if_err), 80'(vecs[i].e_if_err));
            chk($sformatf("v%0d_dm_done", i), 80'(dm_done), 80'(vecs[i].e_dm_done));
            chk($sformatf("v%0d_dm_err", i), 80'(dm_err), 80'(vecs[i].e_dm_err));
            chk($sformatf("v%0d_if_stall", i), 80'(if_stall), 80'(vecs[i].e_if_stall));
            chk($sformatf("v%0d_dm_stall", i), 80'(dm_stall), 80'(vecs[i].e_dm_stall));
            chk($sformatf("v%0d_if_rdata", i), if_rdata, vecs[i].e_if_rdata);
            chk($sformatf("v%0d_dm_rdata", i), 80'(dm_rdata), 80'(vecs[i].e_dm_rdata));
            step();
        end

        // starvation: fetch must win after exactly 4 data grants
        if_req = 1'b1; if_addr = 64'h300;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 64'h200;
        mem_ack = 1'b1;
        dm_grants = 0;
        got_if = 1'b0;
        for (int c = 0; c < 60 && !got_if; c++) begin
            #1;
            if (mem_req && mem_addr == 64'h200) dm_grants++;
            if (mem_req && mem_addr == 64'h300) got_if = 1'b1;
            if (!got_if) step();
        end
        chk("starve_if_granted", 80'(got_if), 80'd1);
        chk("starve_dm_grants", 80'(dm_grants), 80'd4);
        dm_req = 1'b0;
        step();
        chk("starve_if_done", 80'(if_done), 80'd1);
        if_req = 1'b0;
        step();

        // backend never acks: 16 busy cycles then error completion
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 64'h10; mem_ack = 1'b0;
        busy = 0;
        done_seen = 1'b0;
        for (int c = 0; c < 40 && !done_seen; c++) begin
            #1;
            if (dm_done) done_seen = 1'b1;
            else begin
                if (mem_req) busy++;
                step();
            end
        end
        chk("tmo_done_seen", 80'(done_seen), 80'd1);
        chk("tmo_busy_cycles", 80'(busy), 80'd16);
        chk("tmo_dm_err", 80'(dm_err), 80'd1);
        chk("tmo_mem_req_low", 80'(mem_req), 80'd0);
        dm_req = 1'b0;
        step();

        // asynchronous reset in the middle of a data access
        dm_req = 1'b1; dm_addr = 64'h20; mem_ack = 1'b0;
        step();
        #1;
        chk("arst_busy_req", 80'(mem_req), 80'd1);
        #2 rst = 1'b1;
        #1;
        chk("arst_req_drop", 80'(mem_req), 80'd0);
        step();
        rst = 1'b0;
        dm_req = 1'b0;
        quiet_bad = 0;
        for (int c = 0; c < 5; c++) begin
            #1;
            if (dm_done || mem_req) quiet_bad++;
            step();
        end
        chk("arst_no_done", 80'(quiet_bad), 80'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
